// File: rtl/ram_dp_ar_aw_im.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_dp_ar_aw_im: true dual-port RAM, sync write, async read, async clear.  |
// | Optional write-through bypass: RAM_WR_BYPASS_EN.           Rev 1.0         |
// +----------------------------------------------------------------------------+
module ram_dp_ar_aw_im #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_0,
  inout  wire  [DATA_WIDTH-1:0] data_0,
  input  logic                  cs_0,
  input  logic                  we_0,
  input  logic                  oe_0,
  input  logic [ADDR_WIDTH-1:0] address_1,
  inout  wire  [DATA_WIDTH-1:0] data_1,
  input  logic                  cs_1,
  input  logic                  we_1,
  input  logic                  oe_1
);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                  wr_en_0;
  logic                  wr_en_1;
  logic                  rd_en_0;
  logic                  rd_en_1;
  logic [DATA_WIDTH-1:0] rdata_0;
  logic [DATA_WIDTH-1:0] rdata_1;

  assign wr_en_0 = cs_0 & we_0;
  assign wr_en_1 = cs_1 & we_1;
  assign rd_en_0 = cs_0 & ~we_0 & oe_0;
  assign rd_en_1 = cs_1 & ~we_1 & oe_1;

  // Port 0 is applied last so it wins when both ports hit the same word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en_1) mem_q[address_1] <= data_1;
      if (wr_en_0) mem_q[address_0] <= data_0;
    end
  end

`ifdef RAM_WR_BYPASS_EN
  assign rdata_0 = (wr_en_1 && (address_1 == address_0)) ? data_1 : mem_q[address_0];
  assign rdata_1 = (wr_en_0 && (address_0 == address_1)) ? data_0 : mem_q[address_1];
`else
  assign rdata_0 = mem_q[address_0];
  assign rdata_1 = mem_q[address_1];
`endif

  assign data_0 = rd_en_0 ? rdata_0 : {DATA_WIDTH{1'bz}};
  assign data_1 = rd_en_1 ? rdata_1 : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_ar_aw_im.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ram_dp_ar_aw_im: directed plus randomized bench for ram_dp_ar_aw_im.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ram_dp_ar_aw_im;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr [2];
  logic          cs   [2];
  logic          we   [2];
  logic          oe   [2];
  logic          en   [2];
  logic [DW-1:0] drv  [2];
  wire  [DW-1:0] data_0;
  wire  [DW-1:0] data_1;

  logic [DW-1:0] ref_mem [DEPTH];
  int            checks = 0;
  int            errors = 0;

  // The bench owns the bus whenever the RAM must not drive it; an illegal
  // RAM drive then collides with the bench value and corrupts the readback.
  assign data_0 = en[0] ? drv[0] : {DW{1'bz}};
  assign data_1 = en[1] ? drv[1] : {DW{1'bz}};

  always #5 clk = ~clk;

  ram_dp_ar_aw_im #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address_0(addr[0]),
    .data_0   (data_0),
    .cs_0     (cs[0]),
    .we_0     (we[0]),
    .oe_0     (oe[0]),
    .address_1(addr[1]),
    .data_1   (data_1),
    .cs_1     (cs[1]),
    .we_1     (we[1]),
    .oe_1     (oe[1])
  );

  function automatic logic ram_reads(int n);
    return cs[n] && !we[n] && oe[n];
  endfunction

  function automatic logic [DW-1:0] expected(int n);
    if (!ram_reads(n)) return drv[n];
`ifdef RAM_WR_BYPASS_EN
    if (cs[1-n] && we[1-n] && (addr[1-n] == addr[n])) return drv[1-n];
`endif
    return ref_mem[addr[n]];
  endfunction

  task automatic set_port(int n, logic c, logic w, logic o, logic [AW-1:0] a, logic [DW-1:0] v);
    cs[n]   = c;
    we[n]   = w;
    oe[n]   = o;
    addr[n] = a;
    drv[n]  = v;
    en[n]   = !(c && !w && o);
  endtask

  task automatic idle(int n);
    set_port(n, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic check(string tag, int n);
    logic [DW-1:0] obs;
    logic [DW-1:0] exp;
    obs = (n == 0) ? data_0 : data_1;
    exp = expected(n);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s port%0d observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  // Commit the model at the edge using the inputs that were stable before it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (cs[1] && we[1]) ref_mem[addr[1]] = drv[1];
      if (cs[0] && we[0]) ref_mem[addr[0]] = drv[0];
    end
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_model();
    idle(0);
    idle(1);
    tick();
    tick();
    rst = 1'b1;
    tick();

    set_port(1, 1, 0, 1, 7'd5, '0);
    #2 check("reset_state", 1);

    // Asynchronous clear between edges.
    set_port(0, 1, 1, 0, 7'd5, 32'hDEADBEEF);
    tick();
    idle(0);
    #2 check("wr5_before_reset", 1);
    rst = 1'b0;
    clear_model();
    #1 check("async_clear", 1);
    #1 rst = 1'b1;
    tick();
    check("after_release", 1);

    set_port(1, 0, 0, 0, '0, '0);
    set_port(0, 1, 1, 0, 7'd0, 32'h12345678);
    tick();
    set_port(0, 1, 1, 0, 7'd127, 32'hA5A5A5A5);
    tick();
    idle(0);
    set_port(1, 1, 0, 1, 7'd127, '0);
    #1 check("rd_addr127", 1);
    #1 set_port(1, 1, 0, 1, 7'd0, '0);
    #1 check("rd_addr0", 1);

    // Tri-state cases, all at nonzero words so a stray drive shows up.
    set_port(1, 0, 0, 1, 7'd0, '0);
    #1 check("tri_cs1_low", 1);
    tick();
    set_port(1, 1, 0, 0, 7'd0, '0);
    #1 check("tri_oe1_low", 1);
    set_port(1, 1, 1, 1, 7'd0, 32'h12345678);
    #1 check("tri_we1_high", 1);
    set_port(0, 1, 0, 0, 7'd127, '0);
    #1 check("tri_oe0_low", 0);
    set_port(0, 1, 0, 1, 7'd127, '0);
    #1 check("rd_port0", 0);
    tick();
    idle(0);
    idle(1);

    set_port(0, 1, 1, 0, 7'd10, 32'h1);
    tick();
    set_port(0, 1, 1, 0, 7'd10, 32'h2);
    set_port(1, 1, 0, 1, 7'd10, '0);
    #2 check("rdw_before_edge", 1);
    tick();
    idle(0);
    #1 check("rdw_after_edge", 1);

    set_port(0, 1, 1, 0, 7'd3, 32'h11111111);
    set_port(1, 1, 1, 0, 7'd3, 32'h22222222);
    tick();
    idle(0);
    set_port(1, 1, 0, 1, 7'd3, '0);
    #2 check("collision_p0_wins", 1);

    set_port(0, 1, 1, 0, 7'd4, 32'hAAAA5555);
    set_port(1, 1, 1, 0, 7'd6, 32'hBBBB6666);
    tick();
    set_port(0, 1, 0, 1, 7'd6, '0);
    set_port(1, 1, 0, 1, 7'd4, '0);
    #2 check("dual_write_p0", 0);
    check("dual_write_p1", 1);
    tick();

    // Write attempted across an edge while reset is held.
    idle(1);
    set_port(0, 1, 1, 0, 7'd7, 32'hCAFEF00D);
    rst = 1'b0;
    clear_model();
    tick();
    idle(0);
    rst = 1'b1;
    set_port(1, 1, 0, 1, 7'd7, '0);
    #2 check("rst_mid_write", 1);
    tick();

    // Narrow address range so collisions and read-during-write are frequent.
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        set_port(n, ($urandom % 4) != 0, $urandom % 2, $urandom % 2,
                 AW'($urandom % 8), $urandom);
      end
      #2;
      check("rand", 0);
      check("rand", 1);
      tick();
    end

    idle(0);
    for (int a = 0; a < 8; a++) begin
      set_port(1, 1, 0, 1, AW'(a), '0);
      #1 check("final_sweep", 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
